// File: rtl/stage_ex_mc.sv
// Execute stage: forwarded operands, single-cycle ALU and an iterative
// shift-add multiplier that holds ID off through `busy` while it runs.
//
// Handshake: ID may present an instruction (valid_in) on any cycle. It is
// taken on an advancing edge (en && !stall) only while busy == 0; while
// busy == 1 ID must keep the same instruction on its outputs.
module stage_ex_mc #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic                  reg_wr,
    input  logic [REG_ADDR_W-1:0] reg_addr_rd,
    input  logic [REG_ADDR_W-1:0] reg_addr_r1,
    input  logic [REG_ADDR_W-1:0] reg_addr_r2,
    input  logic [3:0]            alu_op,
    input  logic                  alu_src_arg1,
    input  logic                  alu_src_arg2,
    input  logic [DATA_W-1:0]     imm,
    input  logic [DATA_W-1:0]     reg_data_r1,
    input  logic [DATA_W-1:0]     reg_data_r2,
    input  logic                  fwd_wr,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0]     fwd_data,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic                  out_flush
);

    localparam int SH_W  = $clog2(DATA_W);
    // Multiplier bits consumed per MUL edge; MUL_CYCLES-1 edges are spent in MUL.
    localparam int STEP  = (DATA_W + MUL_CYCLES - 2) / (MUL_CYCLES - 1);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]     ma_q, ma_d;
    logic [DATA_W-1:0]     mb_q, mb_d;
    logic [REG_ADDR_W-1:0] mul_rd_q, mul_rd_d;
    logic                  mul_wr_q, mul_wr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_reg_wr_q, out_reg_wr_d;
    logic [REG_ADDR_W-1:0] out_reg_addr_rd_q, out_reg_addr_rd_d;
    logic [DATA_W-1:0]     out_alu_res_q, out_alu_res_d;
    logic                  out_flush_q, out_flush_d;

    logic                  adv;
    logic [DATA_W-1:0]     r1_val, r2_val, op_a, op_b, alu_res, acc_step;
    logic [SH_W-1:0]       shamt;

    assign adv = en && !stall;

    // Forward the MEM result over the register file value; r0 never forwards.
    always_comb begin
        r1_val = reg_data_r1;
        r2_val = reg_data_r2;
        if (fwd_wr && (fwd_addr == reg_addr_r1) && (reg_addr_r1 != '0)) r1_val = fwd_data;
        if (fwd_wr && (fwd_addr == reg_addr_r2) && (reg_addr_r2 != '0)) r2_val = fwd_data;
        op_a  = alu_src_arg1 ? imm : r1_val;
        op_b  = alu_src_arg2 ? imm : r2_val;
        shamt = op_b[SH_W-1:0];
    end

    // Single-cycle ALU; MUL and unused opcodes give 0 here.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a ^ op_b;
            4'd4: alu_res = op_a | op_b;
            4'd5: alu_res = op_a << shamt;
            4'd6: alu_res = op_a >> shamt;
            4'd7: alu_res = DATA_W'($signed(op_a) >>> shamt);
            4'd8: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd9: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default: alu_res = '0;
        endcase
    end

    // One shift-add slice: add the shifted multiplicand for each of the next STEP multiplier bits.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < STEP; i++) begin
            if (mb_q[i]) acc_step = acc_step + (ma_q << i);
        end
    end

    // Next-state and output-register logic; nothing moves unless the stage advances.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        acc_d             = acc_q;
        ma_d              = ma_q;
        mb_d              = mb_q;
        mul_rd_d          = mul_rd_q;
        mul_wr_d          = mul_wr_q;
        out_valid_d       = out_valid_q;
        out_reg_wr_d      = out_reg_wr_q;
        out_reg_addr_rd_d = out_reg_addr_rd_q;
        out_alu_res_d     = out_alu_res_q;
        out_flush_d       = out_flush_q;
        if (adv) begin
            out_flush_d = flush;
            out_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_in && !flush) begin
                        if (alu_op == OP_MUL) begin
                            ma_d     = op_a;
                            mb_d     = op_b;
                            acc_d    = '0;
                            mul_rd_d = reg_addr_rd;
                            mul_wr_d = reg_wr;
                            cnt_d    = CNT_W'(MUL_CYCLES - 1);
                            state_d  = S_MUL;
                        end else begin
                            out_valid_d       = 1'b1;
                            out_alu_res_d     = alu_res;
                            out_reg_wr_d      = reg_wr;
                            out_reg_addr_rd_d = reg_addr_rd;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        // Abort: the partial product is dropped, no result retires.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        acc_d = acc_step;
                        ma_d  = ma_q << STEP;
                        mb_d  = mb_q >> STEP;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            out_valid_d       = 1'b1;
                            out_alu_res_d     = acc_step;
                            out_reg_wr_d      = mul_wr_q;
                            out_reg_addr_rd_d = mul_rd_q;
                            state_d           = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            acc_q             <= '0;
            ma_q              <= '0;
            mb_q              <= '0;
            mul_rd_q          <= '0;
            mul_wr_q          <= 1'b0;
            out_valid_q       <= 1'b0;
            out_reg_wr_q      <= 1'b0;
            out_reg_addr_rd_q <= '0;
            out_alu_res_q     <= '0;
            out_flush_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            acc_q             <= acc_d;
            ma_q              <= ma_d;
            mb_q              <= mb_d;
            mul_rd_q          <= mul_rd_d;
            mul_wr_q          <= mul_wr_d;
            out_valid_q       <= out_valid_d;
            out_reg_wr_q      <= out_reg_wr_d;
            out_reg_addr_rd_q <= out_reg_addr_rd_d;
            out_alu_res_q     <= out_alu_res_d;
            out_flush_q       <= out_flush_d;
        end
    end

    assign busy            = (state_q == S_MUL);
    assign out_valid       = out_valid_q;
    assign out_reg_wr      = out_reg_wr_q;
    assign out_reg_addr_rd = out_reg_addr_rd_q;
    assign out_alu_res     = out_alu_res_q;
    assign out_flush       = out_flush_q;

endmodule
